idecode_pipe: RTL and testbench

- Registered, handshaked, parametrised instruction-decode stage. Sits between fetch and execute/uCode control.
- Splits each 32-bit instruction into class, ALU function, register indices, immediate and multiply-trigger fields.
- Adds a one-entry output register with valid/ready flow control, a sticky halt state, and a multiply-issue interlock that stalls back-to-back multiplies while uCode control is busy.

---
 rtl/idecode_if.sv | 54 +++++
 rtl/idecode_pipe.sv | 181 ++++++++++++++++++
 tb/tb_idecode_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/idecode_if.sv
// Decode-stage bus: fetch-side valid/ready/instruction in, decoded bundle
// with valid/ready out. The stage itself uses the slave view; the
// fetch/execute environment uses the master view.
interface idecode_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic               out_valid;
    logic               out_ready;
    logic               branch;
    logic               load_store;
    logic               data_register;
    logic               data_register_imm;
    logic               special_encoding;
    logic               set_flags;
    logic [2:0]         alu_function;
    logic [3:0]         branch_instruction;
    logic               reg_write;
    logic               reg_read;
    logic [REG_AW-1:0]  out_dest_register;
    logic [REG_AW-1:0]  out_source_first_reg;
    logic [REG_AW-1:0]  out_source_sec_reg;
    logic [IMM_W-1:0]   out_imm;
    logic [1:0]         first_level_decode_out;
    logic [3:0]         second_level_decode_out;
    logic               halt;
    logic               mul_trigger;
    logic [1:0]         mul_type;
    logic               illegal;

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, branch, load_store, data_register,
               data_register_imm, special_encoding, set_flags, alu_function,
               branch_instruction, reg_write, reg_read, out_dest_register,
               out_source_first_reg, out_source_sec_reg, out_imm,
               first_level_decode_out, second_level_decode_out, halt,
               mul_trigger, mul_type, illegal
    );

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, branch, load_store, data_register,
               data_register_imm, special_encoding, set_flags, alu_function,
               branch_instruction, reg_write, reg_read, out_dest_register,
               out_source_first_reg, out_source_sec_reg, out_imm,
               first_level_decode_out, second_level_decode_out, halt,
               mul_trigger, mul_type, illegal
    );
endinterface

// File: rtl/idecode_pipe.sv
// Registered instruction-decode stage with valid/ready flow control, a
// sticky HALT state and a multiply-issue interlock.
// Optional feature macro: IDECODE_ILLEGAL_EN -- flags class-11 encodings
// other than plain branch / HALT as illegal instead of decoding a branch.
module idecode_pipe #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 16,
    parameter int MUL_LAT = 4
) (
    input  logic     clk,
    input  logic     rst,
    idecode_if.slave bus
);
    // Counter needs at least one bit even when the interlock is disabled.
    localparam int         CW      = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [6:0] OP_HALT = 7'b1101000;

    typedef struct packed {
        logic              branch;
        logic              load_store;
        logic              data_register;
        logic              data_register_imm;
        logic              special_encoding;
        logic              set_flags;
        logic [2:0]        alu_function;
        logic [3:0]        branch_instruction;
        logic              reg_write;
        logic              reg_read;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [IMM_W-1:0]  imm;
        logic [1:0]        first_level;
        logic [3:0]        second_level;
        logic              mul_trigger;
        logic [1:0]        mul_type;
        logic              illegal;
    } bundle_t;

    logic [6:0]        op;
    logic [REG_AW-1:0] f_dest, f_src1, f_src2;
    bundle_t           dec;
    bundle_t           bundle_q, bundle_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
    logic              take, mul_block, in_ready, accept;

    // Combinational decode of the instruction currently on the input.
    always_comb begin
        op     = bus.instruction[INSTR_W-1 -: 7];
        f_dest = bus.instruction[INSTR_W-8 -: REG_AW];
        f_src1 = bus.instruction[INSTR_W-8-REG_AW -: REG_AW];
        f_src2 = bus.instruction[INSTR_W-8-2*REG_AW -: REG_AW];
        dec                  = '0;
        dec.first_level      = op[6:5];
        dec.second_level     = op[3:0];
        dec.special_encoding = op[4];
        dec.set_flags        = op[3];
        dec.alu_function     = op[2:0];
        case (op[6:5])
            2'b11: begin
                dec.branch_instruction = 4'(f_dest);
                dec.src1               = f_src1;
                dec.src2               = f_src2;
`ifdef IDECODE_ILLEGAL_EN
                // Only the plain branch group and HALT are legal here;
                // illegal bundles still flow but cannot branch or touch regs.
                if (op[3:0] != 4'b0000 && op != OP_HALT) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.branch   = 1'b1;
                    dec.reg_read = 1'b1;
                end
`else
                dec.branch   = 1'b1;
                dec.reg_read = 1'b1;
`endif
            end
            2'b10: begin
                dec.load_store = 1'b1;
                dec.dest       = f_dest;
                dec.src1       = f_src1;
            end
            2'b01: begin
                dec.data_register = 1'b1;
                dec.dest          = f_dest;
                dec.src1          = f_src1;
                dec.src2          = f_src2;
                dec.reg_read      = 1'b1;
                dec.reg_write     = 1'b1;
            end
            default: begin
                dec.data_register_imm = 1'b1;
                dec.dest              = f_dest;
                dec.src1              = f_src1;
                dec.imm               = bus.instruction[IMM_W-1:0];
                dec.reg_read          = 1'b1;
                dec.reg_write         = 1'b1;
            end
        endcase
        case (op)
            7'b0010000: begin dec.mul_trigger = 1'b1; dec.mul_type = 2'd0; end
            7'b0110000: begin dec.mul_trigger = 1'b1; dec.mul_type = 2'd1; end
            7'b0011000: begin dec.mul_trigger = 1'b1; dec.mul_type = 2'd2; end
            7'b0111000: begin dec.mul_trigger = 1'b1; dec.mul_type = 2'd3; end
            default:    begin dec.mul_trigger = 1'b0; dec.mul_type = 2'd0; end
        endcase
    end

    // Handshake: a multiply is also blocked in the very cycle an older
    // multiply leaves, since the counter has not been loaded yet.
    always_comb begin
        take      = out_valid_q && bus.out_ready;
        mul_block = dec.mul_trigger &&
                    ((mul_cnt_q != '0) ||
                     (take && bundle_q.mul_trigger && (MUL_LAT != 0)));
        in_ready  = !halted_q && (!out_valid_q || bus.out_ready) && !mul_block;
        accept    = bus.in_valid && in_ready;
    end

    // Next state for the output register, halt flag and interlock counter.
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        mul_cnt_d   = mul_cnt_q;
        if (accept) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
            if (op == OP_HALT) halted_d = 1'b1;
        end else if (take) begin
            out_valid_d = 1'b0;
        end
        if (take && bundle_q.mul_trigger) begin
            mul_cnt_d = CW'(MUL_LAT);
        end else if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - CW'(1);
        end
    end

    // State registers; reset drops any in-flight bundle and interlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            mul_cnt_q   <= '0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            mul_cnt_q   <= mul_cnt_d;
        end
    end

    assign bus.in_ready                = in_ready;
    assign bus.out_valid               = out_valid_q;
    assign bus.branch                  = bundle_q.branch;
    assign bus.load_store              = bundle_q.load_store;
    assign bus.data_register           = bundle_q.data_register;
    assign bus.data_register_imm       = bundle_q.data_register_imm;
    assign bus.special_encoding        = bundle_q.special_encoding;
    assign bus.set_flags               = bundle_q.set_flags;
    assign bus.alu_function            = bundle_q.alu_function;
    assign bus.branch_instruction      = bundle_q.branch_instruction;
    assign bus.reg_write               = bundle_q.reg_write;
    assign bus.reg_read                = bundle_q.reg_read;
    assign bus.out_dest_register       = bundle_q.dest;
    assign bus.out_source_first_reg    = bundle_q.src1;
    assign bus.out_source_sec_reg      = bundle_q.src2;
    assign bus.out_imm                 = bundle_q.imm;
    assign bus.first_level_decode_out  = bundle_q.first_level;
    assign bus.second_level_decode_out = bundle_q.second_level;
    assign bus.halt                    = halted_q;
    assign bus.mul_trigger             = bundle_q.mul_trigger;
    assign bus.mul_type                = bundle_q.mul_type;
    // Never set by the decoder unless the illegal-detect feature is built in.
    assign bus.illegal                 = bundle_q.illegal;
endmodule

// File: tb/tb_idecode_pipe.sv
// Testbench for idecode_pipe: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a transaction-level
// model of the stage.
module tb_idecode_pipe;
    localparam int INSTR_W = 32;
    localparam int REG_AW  = 4;
    localparam int IMM_W   = 16;
    localparam int MUL_LAT = 4;
    localparam int OP_HALT = 7'h68;
`ifdef IDECODE_ILLEGAL_EN
    localparam int ILL_EN = 1;
`else
    localparam int ILL_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    idecode_if #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) bus ();

    idecode_pipe #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op, br, ls, dr, dri, spec, sf, alu, bri, rw, rr;
        int dst, s1, s2, imm, fl, sl, mul, mt, ill;
    } exp_t;

    int   npass = 0;
    int   ntot  = 0;
    bit   have, halted, armed;
    exp_t head;
    int   last_take = -100;
    int   cyc = 0;

    function automatic int fld(input logic [31:0] x, input int lsb, input int w);
        return int'((x >> lsb) % (32'd1 << w));
    endfunction

    // Instruction -> expected bundle, straight from the field/class rules.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        int cls, dst, s1, s2;
        e = '{default: 0};
        e.op   = fld(ins, INSTR_W - 7, 7);
        cls    = e.op / 32;
        dst    = fld(ins, INSTR_W - 7 - REG_AW, REG_AW);
        s1     = fld(ins, INSTR_W - 7 - 2 * REG_AW, REG_AW);
        s2     = fld(ins, INSTR_W - 7 - 3 * REG_AW, REG_AW);
        e.fl   = cls;
        e.sl   = e.op % 16;
        e.spec = (e.op / 16) % 2;
        e.sf   = (e.op / 8) % 2;
        e.alu  = e.op % 8;
        if (cls == 3) begin
            e.bri = dst; e.s1 = s1; e.s2 = s2;
            e.ill = (ILL_EN != 0 && e.sl != 0 && e.op != OP_HALT) ? 1 : 0;
            if (e.ill == 0) begin e.br = 1; e.rr = 1; end
        end else if (cls == 2) begin
            e.ls = 1; e.dst = dst; e.s1 = s1;
        end else if (cls == 1) begin
            e.dr = 1; e.dst = dst; e.s1 = s1; e.s2 = s2; e.rr = 1; e.rw = 1;
        end else begin
            e.dri = 1; e.dst = dst; e.s1 = s1; e.imm = fld(ins, 0, IMM_W); e.rr = 1; e.rw = 1;
        end
        if      (e.op == 7'h10) begin e.mul = 1; e.mt = 0; end
        else if (e.op == 7'h30) begin e.mul = 1; e.mt = 1; end
        else if (e.op == 7'h18) begin e.mul = 1; e.mt = 2; end
        else if (e.op == 7'h38) begin e.mul = 1; e.mt = 3; end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: drive inputs at negedge, compare against the model, then
    // advance the model across the coming rising edge.
    task automatic cycle(input bit r, input bit iv, input logic [31:0] ins, input bit ordy);
        exp_t d;
        bit   take, blk, exp_rdy;
        @(negedge clk);
        rst             = r;
        bus.in_valid    = iv;
        bus.instruction = ins;
        bus.out_ready   = ordy;
        #1;
        if (r) begin
            have = 0; halted = 0; last_take = -100; armed = 1;
            cyc++;
            return;
        end
        d       = model_decode(ins);
        take    = have && ordy;
        blk     = (MUL_LAT > 0) && (d.mul != 0) &&
                  ((take && head.mul != 0) || (cyc - last_take <= MUL_LAT));
        exp_rdy = !halted && (!have || ordy) && !blk;
        if (armed) begin
            chk("out_valid", int'(bus.out_valid), int'(have));
            chk("in_ready",  int'(bus.in_ready),  int'(exp_rdy));
            chk("halt",      int'(bus.halt),      int'(halted));
            if (have) begin
                chk("branch",      int'(bus.branch),                  head.br);
                chk("load_store",  int'(bus.load_store),              head.ls);
                chk("data_reg",    int'(bus.data_register),           head.dr);
                chk("data_imm",    int'(bus.data_register_imm),       head.dri);
                chk("special",     int'(bus.special_encoding),        head.spec);
                chk("set_flags",   int'(bus.set_flags),               head.sf);
                chk("alu_fn",      int'(bus.alu_function),            head.alu);
                chk("branch_ins",  int'(bus.branch_instruction),      head.bri);
                chk("reg_write",   int'(bus.reg_write),               head.rw);
                chk("reg_read",    int'(bus.reg_read),                head.rr);
                chk("dest",        int'(bus.out_dest_register),       head.dst);
                chk("src1",        int'(bus.out_source_first_reg),    head.s1);
                chk("src2",        int'(bus.out_source_sec_reg),      head.s2);
                chk("imm",         int'(bus.out_imm),                 head.imm);
                chk("first_lvl",   int'(bus.first_level_decode_out),  head.fl);
                chk("second_lvl",  int'(bus.second_level_decode_out), head.sl);
                chk("mul_trigger", int'(bus.mul_trigger),             head.mul);
                chk("mul_type",    int'(bus.mul_type),                head.mt);
                chk("illegal",     int'(bus.illegal),                 head.ill);
            end
        end
        if (take && head.mul != 0) last_take = cyc;
        if (iv && exp_rdy) begin
            have = 1; head = d;
            if (d.op == OP_HALT) halted = 1;
        end else if (take) begin
            have = 0;
        end
        cyc++;
    endtask

    initial begin
        int n;
        logic [31:0] ins;
        logic [6:0]  mops [4];
        bus.in_valid = 1'b0; bus.instruction = '0; bus.out_ready = 1'b1;
        mops[0] = 7'h10; mops[1] = 7'h30; mops[2] = 7'h18; mops[3] = 7'h38;

        cycle(1, 0, 0, 1); cycle(1, 0, 0, 1);
        // muli right after reset
        cycle(0, 1, 32'h20640005, 1);
        chk("lit_rst_in_ready", int'(bus.in_ready), 1);
        chk("lit_rst_out_valid", int'(bus.out_valid), 0);
        chk("lit_rst_halt", int'(bus.halt), 0);
        cycle(0, 1, 32'hC0424000, 1);
        chk("lit_muli_valid", int'(bus.out_valid), 1);
        chk("lit_muli_dri", int'(bus.data_register_imm), 1);
        chk("lit_muli_mul", int'(bus.mul_trigger), 1);
        chk("lit_muli_type", int'(bus.mul_type), 0);
        chk("lit_muli_dest", int'(bus.out_dest_register), 3);
        chk("lit_muli_src1", int'(bus.out_source_first_reg), 2);
        chk("lit_muli_imm", int'(bus.out_imm), 5);
        chk("lit_muli_rw", int'(bus.reg_write), 1);
        cycle(0, 0, 0, 1);
        chk("lit_br_branch", int'(bus.branch), 1);
        chk("lit_br_cond", int'(bus.branch_instruction), 2);
        chk("lit_br_src1", int'(bus.out_source_first_reg), 1);
        chk("lit_br_src2", int'(bus.out_source_sec_reg), 2);
        chk("lit_br_rr", int'(bus.reg_read), 1);
        chk("lit_br_rw", int'(bus.reg_write), 0);
        chk("lit_br_mul", int'(bus.mul_trigger), 0);
        repeat (6) cycle(0, 0, 0, 1);

        // Back-to-back multiplies: blocked in the take cycle plus MUL_LAT more.
        cycle(0, 1, 32'h6028A000, 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 32'h20640005, 1);
            if (bus.in_ready) break;
            n++;
        end
        chk("lit_mul_hold_b2b", n, 5);
        repeat (6) cycle(0, 0, 0, 1);

        // A non-multiply slips into the window; the next multiply waits 4.
        cycle(0, 1, 32'h6028A000, 1);
        cycle(0, 1, 32'hC0424000, 1);
        chk("lit_nonmul_in_window", int'(bus.in_ready), 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 32'h20640005, 1);
            if (bus.in_ready) break;
            n++;
        end
        chk("lit_mul_hold_window", n, 4);
        repeat (6) cycle(0, 0, 0, 1);

        // Backpressure for 3 cycles, then no-bubble release.
        cycle(0, 1, 32'h20640005, 1);
        repeat (3) begin
            cycle(0, 1, 32'hC0424000, 0);
            chk("lit_bp_in_ready", int'(bus.in_ready), 0);
            chk("lit_bp_imm_hold", int'(bus.out_imm), 5);
        end
        cycle(0, 1, 32'hC0424000, 1);
        chk("lit_bp_release", int'(bus.in_ready), 1);
        cycle(0, 0, 0, 1);
        chk("lit_bp_next_valid", int'(bus.out_valid), 1);
        chk("lit_bp_next_branch", int'(bus.branch), 1);
        repeat (6) cycle(0, 0, 0, 1);

        // HALT: one bundle, then stuck until reset.
        cycle(0, 1, 32'hD0000000, 1);
        n = 0;
        repeat (5) begin
            cycle(0, 1, 32'h20640005, 1);
            if (bus.out_valid) n++;
        end
        chk("lit_halt_bundles", n, 1);
        chk("lit_halt_sticky", int'(bus.halt), 1);
        chk("lit_halt_in_ready", int'(bus.in_ready), 0);
        cycle(1, 0, 0, 1);
        cycle(0, 1, 32'h20640005, 1);
        chk("lit_halt_rst_ready", int'(bus.in_ready), 1);
        chk("lit_halt_rst_halt", int'(bus.halt), 0);
        repeat (6) cycle(0, 0, 0, 1);

        // Class-11 with non-zero second-level decode.
        cycle(0, 1, 32'hC2000000, 1);
        cycle(0, 0, 0, 1);
        chk("lit_ill_illegal", int'(bus.illegal), ILL_EN);
        chk("lit_ill_branch", int'(bus.branch), 1 - ILL_EN);

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            ins = $urandom;
            n = $urandom_range(0, 9);
            if (n < 4) ins[31:25] = mops[n];
            else if (n == 4 && $urandom_range(0, 29) == 0) ins[31:25] = 7'h68;
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, ins,
                  $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
